// File: rtl/bcd_decoder_pkg.sv
// Shared types and constants for the sequential binary-to-BCD 7-segment decoder.
package bcd_decoder_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

  // Active-low glyph, index 0 = segment a ... index 6 = segment g
  typedef logic [0:6] glyph_t;

  localparam glyph_t SEG_0     = 7'b0000001;
  localparam glyph_t SEG_1     = 7'b1001111;
  localparam glyph_t SEG_2     = 7'b0010010;
  localparam glyph_t SEG_3     = 7'b0000110;
  localparam glyph_t SEG_4     = 7'b1001100;
  localparam glyph_t SEG_5     = 7'b0100100;
  localparam glyph_t SEG_6     = 7'b0100000;
  localparam glyph_t SEG_7     = 7'b0001111;
  localparam glyph_t SEG_8     = 7'b0000000;
  localparam glyph_t SEG_9     = 7'b0000100;
  localparam glyph_t SEG_BLANK = 7'b1111111;

  localparam int NUM_DIGITS = 4;

  // Double-dabble correction: bump every nibble >= 5 by 3 ahead of the shift
  function automatic logic [4*NUM_DIGITS-1:0] bcd_add3(input logic [4*NUM_DIGITS-1:0] b);
    logic [4*NUM_DIGITS-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_decoder_seg7_encoder.sv
// Combinational BCD nibble to active-low 7-segment glyph; 10..15 render blank.
module seg7_encoder
  import bcd_decoder_pkg::*;
(
  input  logic [3:0] bcd,
  output glyph_t     seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_decoder.sv
// Continuously converts SW to four 7-segment digits via one-bit-per-cycle double dabble.
// Optional: define BCD_LEADING_ZERO_BLANK_EN to blank leading zeros on HEX3..HEX1.
module bcd_decoder
  import bcd_decoder_pkg::*;
#(
  parameter int IN = 10,
  parameter int S  = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IN-1:0] SW,
  output logic [0:S-1]  HEX0,
  output logic [0:S-1]  HEX1,
  output logic [0:S-1]  HEX2,
  output logic [0:S-1]  HEX3
);

  localparam int CW = $clog2(IN + 1);
  localparam int BW = 4 * NUM_DIGITS;

  state_e                            state_q, state_d;
  logic [IN-1:0]                     sh_q, sh_d;
  logic [BW-1:0]                     bcd_q, bcd_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][0:6]        hex_q, hex_d;
  logic [NUM_DIGITS-1:0][0:6]        glyph;
  logic [NUM_DIGITS-1:0][0:6]        shown;
  logic [BW-1:0]                     adj;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg7_encoder u_enc (
      .bcd (bcd_q[4*g +: 4]),
      .seg (glyph[g])
    );
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead;
  always_comb begin
    lead    = '0;
    lead[3] = (bcd_q[15:12] == 4'd0);
    lead[2] = lead[3] && (bcd_q[11:8] == 4'd0);
    lead[1] = lead[2] && (bcd_q[7:4] == 4'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      shown[i] = lead[i] ? SEG_BLANK : glyph[i];
    end
  end
`else
  always_comb begin
    shown = glyph;
  end
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    adj     = bcd_add3(bcd_q);
    case (state_q)
      IDLE: begin
        sh_d    = SW;
        bcd_d   = '0;
        cnt_d   = CW'(IN);
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d         = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = LOAD;
      end
      LOAD: begin
        hex_d   = shown;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];

endmodule

// File: tb/tb_bcd_decoder.sv
// Directed self-checking bench for bcd_decoder (IN=10, S=7).
module tb_bcd_decoder;

  localparam int IN     = 10;
  localparam int S      = 7;
  localparam int SETTLE = 2 * (IN + 2) + 1;

  localparam logic [0:6] G0 = 7'b0000001;
  localparam logic [0:6] G1 = 7'b1001111;
  localparam logic [0:6] G2 = 7'b0010010;
  localparam logic [0:6] G3 = 7'b0000110;
  localparam logic [0:6] G4 = 7'b1001100;
  localparam logic [0:6] G5 = 7'b0100100;
  localparam logic [0:6] G7 = 7'b0001111;
  localparam logic [0:6] GB = 7'b1111111;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [0:6] LZ = GB;
`else
  localparam logic [0:6] LZ = G0;
`endif

  logic          clk;
  logic          rst_n;
  logic [IN-1:0] SW;
  logic [0:S-1]  HEX0, HEX1, HEX2, HEX3;
  logic [27:0]   exp_v;
  int            nchk;
  int            nfail;

  bcd_decoder #(.IN(IN), .S(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SW    (SW),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2),
    .HEX3  (HEX3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    SW    = 10'd5;
    exp_v = {GB, GB, GB, GB};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nchk++;
      if ({HEX3, HEX2, HEX1, HEX0} !== exp_v) begin
        nfail++;
        $display("FAIL reset_blank cyc=%0d got=%b want=%b", i, {HEX3, HEX2, HEX1, HEX0}, exp_v);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_value(input logic [IN-1:0] v, input logic [27:0] e, input string nm);
    @(negedge clk);
    SW = v;
    repeat (SETTLE) @(negedge clk);
    nchk++;
    if ({HEX3, HEX2, HEX1, HEX0} !== e) begin
      nfail++;
      $display("FAIL %s got=%b want=%b", nm, {HEX3, HEX2, HEX1, HEX0}, e);
    end
  endtask

  task automatic test_digits();
    test_value(10'd1,    {LZ, LZ, LZ, G1}, "one");
    test_value(10'd10,   {LZ, LZ, G1, G0}, "ten");
    test_value(10'd20,   {LZ, LZ, G2, G0}, "twenty");
    test_value(10'd100,  {LZ, G1, G0, G0}, "hundred");
    test_value(10'd152,  {LZ, G1, G5, G2}, "v152");
    test_value(10'd1023, {G1, G0, G2, G3}, "max1023");
    test_value(10'd0,    {LZ, LZ, LZ, G0}, "zero");
    test_value(10'd704,  {LZ, G7, G0, G4}, "v704");
  endtask

  // Reset released on a negedge pins the FSM phase: first posedge captures,
  // the 12th posedge is LOAD.
  task automatic test_toggle_during_shift();
    @(negedge clk);
    rst_n = 1'b0;
    SW    = 10'd7;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      SW = (i % 2) ? 10'd999 : 10'd555;
      nchk++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {GB, GB, GB, GB}) begin
        nfail++;
        $display("FAIL toggle_pre_load i=%0d got=%b", i, {HEX3, HEX2, HEX1, HEX0});
      end
    end
    @(negedge clk);
    SW = 10'd42;
    @(negedge clk);
    exp_v = {LZ, LZ, LZ, G7};
    nchk++;
    if ({HEX3, HEX2, HEX1, HEX0} !== exp_v) begin
      nfail++;
      $display("FAIL toggle_first got=%b want=%b", {HEX3, HEX2, HEX1, HEX0}, exp_v);
    end
    for (int i = 13; i <= 22; i++) begin
      @(negedge clk);
      SW = (i % 2) ? 10'd888 : 10'd333;
      nchk++;
      if ({HEX3, HEX2, HEX1, HEX0} !== exp_v) begin
        nfail++;
        $display("FAIL toggle_hold i=%0d got=%b want=%b", i, {HEX3, HEX2, HEX1, HEX0}, exp_v);
      end
    end
    @(negedge clk);
    SW = 10'd0;
    @(negedge clk);
    exp_v = {LZ, LZ, G4, G2};
    nchk++;
    if ({HEX3, HEX2, HEX1, HEX0} !== exp_v) begin
      nfail++;
      $display("FAIL toggle_second got=%b want=%b", {HEX3, HEX2, HEX1, HEX0}, exp_v);
    end
  endtask

  task automatic test_reset_mid_shift();
    test_value(10'd1023, {G1, G0, G2, G3}, "pre_abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({HEX3, HEX2, HEX1, HEX0} !== {GB, GB, GB, GB}) begin
      nfail++;
      $display("FAIL abort_blank got=%b", {HEX3, HEX2, HEX1, HEX0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= IN; i++) begin
      @(negedge clk);
      nchk++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {GB, GB, GB, GB}) begin
        nfail++;
        $display("FAIL abort_no_stale cyc=%0d got=%b", i, {HEX3, HEX2, HEX1, HEX0});
      end
    end
    @(negedge clk);
    exp_v = {G1, G0, G2, G3};
    nchk++;
    if ({HEX3, HEX2, HEX1, HEX0} !== exp_v) begin
      nfail++;
      $display("FAIL first_after_reset got=%b want=%b", {HEX3, HEX2, HEX1, HEX0}, exp_v);
    end
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    rst_n = 1'b0;
    SW    = '0;
    test_reset();
    test_digits();
    test_toggle_during_shift();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/bcd_decoder.md
BCD_DECODER -- requirements
Module: bcd_decoder

Interface
REQ-001 The block SHALL have parameter IN, default 10, giving the binary input width; the legal range SHALL be 1..13.
REQ-002 The block SHALL have parameter S, default 7, giving the segments per display; only 7 SHALL be legal.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 SW  input  IN  SHALL carry the unsigned binary value to display.
REQ-006 HEX0  output  [0:S-1]  SHALL drive the ones digit; bit 0 = segment a ... bit 6 = segment g; active-low.
REQ-007 HEX1, HEX2, HEX3  output  [0:S-1]  SHALL drive the tens, hundreds and thousands digits, with the same encoding as HEX0.

Function
REQ-008 The block SHALL convert SW into four BCD digits using sequential double-dabble: shift left one bit per cycle, with add-3 on any nibble >= 5 before each shift.
REQ-009 The FSM SHALL have exactly three states: IDLE, SHIFT and LOAD.
REQ-010 IDLE SHALL capture SW into a shift register, clear the BCD accumulator, load the bit counter with IN, and go to SHIFT on the next cycle.
REQ-011 SHIFT SHALL perform one add-3/shift step per cycle for IN cycles, then go to LOAD.
REQ-012 LOAD SHALL register the four encoded digits onto HEX0..HEX3 and return to IDLE.
REQ-013 The converter SHALL run continuously, so any SW value held stable is displayed at most 2*(IN+2) cycles after it changes.
REQ-014 For a stable SW value, latency from capture in IDLE to updated outputs SHALL be IN+2 cycles.
REQ-015 A change of SW during SHIFT SHALL NOT affect the conversion in progress; the new value is taken at the next IDLE.
REQ-016 HEX outputs SHALL change only in LOAD and SHALL be glitch-free registered outputs.
REQ-017 Digit glyphs, active-low, as [0:6]:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
REQ-018 Any BCD nibble value 10..15 SHALL encode as blank (1111111).
REQ-019 Maximum input 2^IN-1 SHALL display correctly; for IN=10, 1023 SHALL show 1,0,2,3.
REQ-020 Input 0 SHALL display 0000 when blanking is not compiled in.

Reset
REQ-021 While rst_n=0, the FSM SHALL be in IDLE and the shift register, accumulator and counter SHALL be zero.
REQ-022 While rst_n=0, HEX0..HEX3 SHALL be 1111111 (all segments off).
REQ-023 Assertion of rst_n mid-conversion SHALL abort the conversion immediately with no output update.
REQ-024 After rst_n deasserts, the first valid display SHALL appear IN+2 cycles later.

Configuration
REQ-025 With macro BCD_LEADING_ZERO_BLANK_EN defined, leading zero digits SHALL be blanked (1111111) from HEX3 down to HEX1; HEX0 SHALL never be blanked.
REQ-026 Without BCD_LEADING_ZERO_BLANK_EN, all four digits SHALL always be shown, including leading zeros.

Structure
REQ-027 Package bcd_decoder_pkg SHALL hold:
- the FSM state typedef
- the ten glyph constants
- the SEG_BLANK constant
- the digit-count constant (4)
REQ-028 Sub-module seg7_encoder (4-bit BCD in, 7-bit active-low glyph out, combinational) SHALL be instantiated four times.

Verification
REQ-029 rst_n=0 with SW=10'd5 -> HEX0..HEX3 = 1111111 throughout reset.
REQ-030 SW=10'd1 held 2*(IN+2) cycles -> HEX0=1001111; HEX1..HEX3=0000001 (blank with macro).
REQ-031 SW=10'd10, then 10'd20 -> HEX1=1001111, HEX0=0000001, then HEX1=0010010, HEX0=0000001.
REQ-032 SW=10'd100, then 10'd152 -> HEX2,HEX1,HEX0 = 1001111,0000001,0000001, then 1001111,0100100,0010010.
REQ-033 SW=10'd1023 -> HEX3..HEX0 = 1001111,0000001,0010010,0000110.
REQ-034 Toggle SW every cycle during SHIFT -> outputs only ever show values captured in IDLE; rst_n pulse mid-SHIFT -> outputs blank, no stale update.
